// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared widths, zero-register index, write request type and grant encoding
package regfile_arb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;
  typedef struct packed {
    logic [ADDR_W-1:0] da;
    logic [DATA_W-1:0] d;
  } wr_req_t;
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;
endpackage

// File: rtl/wr_req_fifo.sv
// wr_req_fifo: DEPTH-entry write request FIFO; push ignored when full, pop ignored when empty
module wr_req_fifo
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    push,
  input  wr_req_t wdata,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wr_req_t head
);
  localparam int AW = $clog2(DEPTH);
  wr_req_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign head = mem_q[rp_q];
  always_comb begin
    push_ok = push && !full;
    pop_ok = pop && !empty;
    wp_d = wp_q + AW'(push_ok);
    rp_d = rp_q + AW'(pop_ok);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wp_q] <= wdata;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin ALU/load writeback onto one register-file write port; REGFILE_ARB_FWD_EN adds write-through forwarding
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_da,
  input  logic [DATA_W-1:0] alu_d,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_da,
  input  logic [DATA_W-1:0] mem_d,
  output logic              rf_w,
  output logic [ADDR_W-1:0] rf_da,
  output logic [DATA_W-1:0] rf_d,
`ifdef REGFILE_ARB_FWD_EN
  input  logic [ADDR_W-1:0] sa,
  input  logic [ADDR_W-1:0] sb,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  output logic [DATA_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_b,
`endif
  output logic              idle
);
  wr_req_t alu_head, mem_head, head;
  logic alu_full, alu_empty, mem_full, mem_empty;
  logic req_any, gnt_mem, alu_pop, mem_pop;
  gnt_e last_q, last_d;
  logic rf_w_q, rf_w_d;
  logic [ADDR_W-1:0] rf_da_q, rf_da_d;
  logic [DATA_W-1:0] rf_d_q, rf_d_d;
  assign alu_ready = !reset && !alu_full;
  assign mem_ready = !reset && !mem_full;
  wr_req_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clock(clock), .reset(reset), .push(alu_valid && alu_ready), .wdata('{da: alu_da, d: alu_d}),
    .pop(alu_pop), .full(alu_full), .empty(alu_empty), .head(alu_head)
  );
  wr_req_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clock(clock), .reset(reset), .push(mem_valid && mem_ready), .wdata('{da: mem_da, d: mem_d}),
    .pop(mem_pop), .full(mem_full), .empty(mem_empty), .head(mem_head)
  );
  always_comb begin
    req_any = !alu_empty || !mem_empty;
    gnt_mem = !mem_empty && (alu_empty || last_q == GNT_ALU);
    head = gnt_mem ? mem_head : alu_head;
    alu_pop = req_any && !gnt_mem;
    mem_pop = gnt_mem;
    last_d = req_any ? (gnt_mem ? GNT_MEM : GNT_ALU) : last_q;
    rf_w_d = req_any && head.da != ZERO_REG;
    rf_da_d = rf_w_d ? head.da : rf_da_q;
    rf_d_d = rf_w_d ? head.d : rf_d_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= GNT_MEM;
      rf_w_q <= 1'b0;
      rf_da_q <= '0;
      rf_d_q <= '0;
    end else begin
      last_q <= last_d;
      rf_w_q <= rf_w_d;
      rf_da_q <= rf_da_d;
      rf_d_q <= rf_d_d;
    end
  end
  assign rf_w = rf_w_q;
  assign rf_da = rf_da_q;
  assign rf_d = rf_d_q;
  assign idle = alu_empty && mem_empty && !rf_w_q;
`ifdef REGFILE_ARB_FWD_EN
  assign fwd_a = (rf_w_q && rf_da_q == sa && sa != ZERO_REG) ? rf_d_q : rf_a;
  assign fwd_b = (rf_w_q && rf_da_q == sb && sb != ZERO_REG) ? rf_d_q : rf_b;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: queue-based reference model checked every cycle plus directed literal checks
module tb_regfile_write_arbiter;
  localparam int DEPTH = 2;
  typedef struct {
    logic [4:0] da;
    logic [63:0] d;
  } ent_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic alu_ready, mem_ready, rf_w, idle;
  logic [4:0] alu_da = '0, mem_da = '0, rf_da;
  logic [63:0] alu_d = '0, mem_d = '0, rf_d;
`ifdef REGFILE_ARB_FWD_EN
  logic [4:0] sa = '0, sb = '0;
  logic [63:0] rf_a = '0, rf_b = '0, fwd_a, fwd_b;
`endif
  int checks = 0;
  int errors = 0;
  ent_t aq[$], mq[$], wlog[$];
  bit last_mem, ew, g_mem, a_acc_m, m_acc_m;
  logic [4:0] eda;
  logic [63:0] ed;
  ent_t h;
  regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_da(alu_da), .alu_d(alu_d),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_da(mem_da), .mem_d(mem_d),
    .rf_w(rf_w), .rf_da(rf_da), .rf_d(rf_d),
`ifdef REGFILE_ARB_FWD_EN
    .sa(sa), .sb(sb), .rf_a(rf_a), .rf_b(rf_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
`endif
    .idle(idle)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clock) begin
    if (reset) begin
      aq.delete();
      mq.delete();
      ew = 0;
      eda = '0;
      ed = '0;
      last_mem = 1;
    end else begin
      a_acc_m = alu_valid && aq.size() < DEPTH;
      m_acc_m = mem_valid && mq.size() < DEPTH;
      ew = 0;
      if (aq.size() != 0 || mq.size() != 0) begin
        g_mem = mq.size() != 0 && (aq.size() == 0 || !last_mem);
        if (g_mem) h = mq.pop_front();
        else h = aq.pop_front();
        last_mem = g_mem;
        if (h.da != 5'd31) begin
          ew = 1;
          eda = h.da;
          ed = h.d;
        end
      end
      if (a_acc_m) aq.push_back('{alu_da, alu_d});
      if (m_acc_m) mq.push_back('{mem_da, mem_d});
    end
    #1;
    chk("rf_w", rf_w, ew);
    chk("rf_da", rf_da, eda);
    chk("rf_d", rf_d, ed);
    chk("alu_ready", alu_ready, !reset && aq.size() < DEPTH);
    chk("mem_ready", mem_ready, !reset && mq.size() < DEPTH);
    chk("idle", idle, aq.size() == 0 && mq.size() == 0 && !ew);
    if (rf_w) wlog.push_back('{rf_da, rf_d});
  end
  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("idle_reached", idle, 1);
  endtask
  task automatic run_stream(input int na, input int abase, input int nm, input int mbase, output int stall);
    int ai = 0, mi = 0, c = 0;
    bit a_acc = 0, m_acc = 0;
    stall = -1;
    while (c < 300 && !(ai == na && mi == nm)) begin
      @(negedge clock);
      c++;
      if (a_acc) ai++;
      if (m_acc) mi++;
      alu_valid = ai < na;
      alu_da = 5'(abase + ai);
      alu_d = 64'hA000 + 64'(ai);
      mem_valid = mi < nm;
      mem_da = 5'(mbase + mi);
      mem_d = 64'hB000 + 64'(mi);
      if (mem_valid && !mem_ready && stall < 0) stall = mi;
      a_acc = alu_valid && alu_ready;
      m_acc = mem_valid && mem_ready;
    end
    alu_valid = 0;
    mem_valid = 0;
    chk("stream_done", 64'(ai + mi), 64'(na + nm));
  endtask
  initial begin
    int stall, n0, ka, km;
    int alt[12];
    alt = '{1, 10, 2, 11, 3, 12, 4, 13, 5, 14, 6, 15};
    alu_valid = 1;
    alu_da = 5'd3;
    repeat (2) @(negedge clock);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_rf_w", rf_w, 0);
    chk("rst_rf_da", rf_da, 0);
    reset = 0;
    alu_valid = 0;
    @(negedge clock);
    chk("post_rst_ready", alu_ready, 1);
    chk("post_rst_idle", idle, 1);
    wlog.delete();
    run_stream(6, 1, 6, 10, stall);
    wait_idle();
    chk("alt_count", 64'(wlog.size()), 12);
    for (int i = 0; i < 12 && i < wlog.size(); i++) chk($sformatf("alt_da%0d", i), wlog[i].da, 5'(alt[i]));
    wlog.delete();
    run_stream(8, 16, 4, 24, stall);
    wait_idle();
    chk("mem_stall_after", 64'(stall), 2);
    chk("flood_count", 64'(wlog.size()), 12);
    ka = 0;
    km = 0;
    foreach (wlog[i]) begin
      if (wlog[i].da >= 5'd24) begin
        chk("mem_order", wlog[i].d, 64'hB000 + 64'(km));
        km++;
      end else begin
        chk("alu_order", wlog[i].d, 64'hA000 + 64'(ka));
        ka++;
      end
    end
    chk("mem_all", 64'(km), 4);
    alu_valid = 1;
    alu_da = 5'd5;
    alu_d = 64'h1234;
    @(negedge clock);
    alu_valid = 0;
    chk("lat_early", rf_w, 0);
    @(negedge clock);
    chk("single_w", rf_w, 1);
    chk("single_da", rf_da, 5);
    chk("single_d", rf_d, 64'h1234);
`ifdef REGFILE_ARB_FWD_EN
    sa = 5'd5;
    rf_a = 64'h11;
    sb = 5'd31;
    rf_b = 64'h22;
    #1;
    chk("fwd_a_hit", fwd_a, 64'h1234);
    chk("fwd_b_zero", fwd_b, 64'h22);
    sb = 5'd6;
    #1;
    chk("fwd_b_miss", fwd_b, 64'h22);
`endif
    @(negedge clock);
    chk("single_off", rf_w, 0);
    chk("single_hold", rf_da, 5);
`ifdef REGFILE_ARB_FWD_EN
    chk("fwd_a_nowrite", fwd_a, 64'h11);
`endif
    alu_valid = 1;
    alu_da = 5'd31;
    alu_d = 64'hFFFF;
    @(negedge clock);
    alu_valid = 0;
    mem_valid = 1;
    mem_da = 5'd9;
    mem_d = 64'h55;
    @(negedge clock);
    mem_valid = 0;
    chk("zero_no_write", rf_w, 0);
    chk("zero_hold_da", rf_da, 5);
    @(negedge clock);
    chk("zero_next_w", rf_w, 1);
    chk("zero_next_da", rf_da, 9);
    chk("zero_next_d", rf_d, 64'h55);
    wait_idle();
    alu_valid = 1;
    mem_valid = 1;
    alu_da = 5'd2;
    mem_da = 5'd12;
    repeat (3) @(negedge clock);
    reset = 1;
    @(negedge clock);
    chk("midrst_w", rf_w, 0);
    chk("midrst_ready", alu_ready, 0);
    reset = 0;
    alu_valid = 0;
    mem_valid = 0;
    n0 = wlog.size();
    repeat (4) @(negedge clock);
    chk("midrst_no_write", 64'(wlog.size() - n0), 0);
    chk("midrst_idle", idle, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
